bist_mem_responder: RTL and testbench

- Memory-side responder for the BIST engine: a 2^ADR_SIZE x DATA_SIZE RAM model behind a four-phase req/ack handshake.
- The BIST initiator issues write/read commands; this block services them with a fixed write latency and a parameterised read latency.
- A built-in fault-injection unit (stuck-at / invert-on-read at one address) lets benches check that BIST raises status on a corrupted cell, without hierarchical force/release.

---
 rtl/bist_mem_responder_if.sv | 24 ++
 rtl/bist_mem_responder.sv | 152 +++++++++++++++
 tb/tb_bist_mem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_mem_responder_if.sv
// Request/acknowledge bus between the BIST initiator and the memory responder.
// The initiator holds req with a stable command until it sees ack.
interface bist_mem_responder_if #(
    parameter int ADR_SIZE  = 4,
    parameter int DATA_SIZE = 8
);
    logic                 req;
    logic                 we;
    logic [ADR_SIZE-1:0]  addr;
    logic [DATA_SIZE-1:0] wdata;
    logic [DATA_SIZE-1:0] rdata;
    logic                 ack;
    logic                 busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy
    );
endinterface

// File: rtl/bist_mem_responder.sv
// RAM model answering BIST commands, with fixed write latency, programmable read latency
// and a single-address fault injector (stuck-at-0/1, invert-on-read).
module bist_mem_responder #(
    parameter int ADR_SIZE  = 4,
    parameter int DATA_SIZE = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    bist_mem_responder_if.slave   bus,
    input  logic                  fi_en,
    input  logic [1:0]            fi_mode,
    input  logic [ADR_SIZE-1:0]   fi_addr,
    input  logic [DATA_SIZE-1:0]  fi_mask,
    output logic [7:0]            fi_hits
);
    localparam int         DEPTH    = 1 << ADR_SIZE;
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t               state_q, state_d;
    logic [ADR_SIZE-1:0]  addr_q, addr_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           hits_q, hits_d;
    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] mem_d [DEPTH];

    logic                 fault_hit;
    logic                 rd_done;
    logic [DATA_SIZE-1:0] wr_word;
    logic [DATA_SIZE-1:0] rd_word;

    // Fault controls are looked at live, at the edge that completes the access.
    assign fault_hit = fi_en && (fi_mode != 2'b00) && (addr_q == fi_addr);
    assign rd_done   = (cnt_q == RD_LAT_C);

    always_comb begin
        wr_word = wdata_q;
        rd_word = mem_q[addr_q];
        if (fault_hit) begin
            case (fi_mode)
                2'b01: begin
                    wr_word = wdata_q & ~fi_mask;
                    rd_word = mem_q[addr_q] & ~fi_mask;
                end
                2'b10: begin
                    wr_word = wdata_q | fi_mask;
                    rd_word = mem_q[addr_q] | fi_mask;
                end
                2'b11: begin
                    wr_word = wdata_q;
                    rd_word = mem_q[addr_q] ^ fi_mask;
                end
                default: begin
                    wr_word = wdata_q;
                    rd_word = mem_q[addr_q];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hits_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req) state_d = bus.we ? WRITE : READ;
            WRITE:   state_d = DONE;
            READ:    if (rd_done) state_d = DONE;
            DONE:    if (!bus.req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ack is a pulse: it is only ever raised on the way into DONE and falls on the next edge.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        hits_d  = hits_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    busy_d  = 1'b1;
                    cnt_d   = 4'd1;
                end
            end
            WRITE: begin
                mem_d[addr_q] = wr_word;
                ack_d         = 1'b1;
                if (fault_hit && hits_q != 8'hFF) hits_d = hits_q + 8'd1;
            end
            READ: begin
                if (rd_done) begin
                    rdata_d = rd_word;
                    ack_d   = 1'b1;
                    if (fault_hit && hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (!bus.req) busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign fi_hits   = hits_q;

    ack_is_pulse: assert property (@(posedge clk) disable iff (rst) ack_q |=> !ack_q);
    ack_while_busy: assert property (@(posedge clk) disable iff (rst) ack_q |-> busy_q);

endmodule

// File: tb/tb_bist_mem_responder.sv
// Randomised bench for bist_mem_responder: drives req/ack transactions and compares
// latency, read data and fault-hit count with a word-array reference model.
module tb_bist_mem_responder;
    localparam int ADR_SIZE  = 4;
    localparam int DATA_SIZE = 8;
    localparam int RD_LAT    = 2;
    localparam int DEPTH     = 1 << ADR_SIZE;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 fi_en;
    logic [1:0]           fi_mode;
    logic [ADR_SIZE-1:0]  fi_addr;
    logic [DATA_SIZE-1:0] fi_mask;
    logic [7:0]           fi_hits;

    bist_mem_responder_if #(.ADR_SIZE(ADR_SIZE), .DATA_SIZE(DATA_SIZE)) bus ();

    bist_mem_responder #(
        .ADR_SIZE (ADR_SIZE),
        .DATA_SIZE(DATA_SIZE),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .fi_en  (fi_en),
        .fi_mode(fi_mode),
        .fi_addr(fi_addr),
        .fi_mask(fi_mask),
        .fi_hits(fi_hits)
    );

    always #5 clk = ~clk;

    logic [DATA_SIZE-1:0] modelMem [DEPTH];
    int                   modelHits;
    logic [DATA_SIZE-1:0] modelRdata;
    int                   checks   = 0;
    int                   failures = 0;
    logic [DATA_SIZE-1:0] lastRdata;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic bit faultActive(input logic [ADR_SIZE-1:0] a);
        return fi_en && (fi_mode != 2'b00) && (a == fi_addr);
    endfunction

    function automatic logic [DATA_SIZE-1:0] faulty(input logic [DATA_SIZE-1:0] v, input bit isRead);
        case (fi_mode)
            2'b01:   return v & ~fi_mask;
            2'b10:   return v | fi_mask;
            2'b11:   return isRead ? (v ^ fi_mask) : v;
            default: return v;
        endcase
    endfunction

    task automatic modelReset();
        foreach (modelMem[i]) modelMem[i] = '0;
        modelHits  = 0;
        modelRdata = '0;
    endtask

    // One full four-phase transaction; the model is updated first because fi_* stay
    // constant for the whole transaction.
    task automatic applyStimulus(input bit isWrite, input logic [ADR_SIZE-1:0] a,
                                 input logic [DATA_SIZE-1:0] d, input int holdCycles,
                                 input bit earlyDrop);
        int lat;
        int expLat;
        bit hit;
        hit = faultActive(a);
        if (isWrite) begin
            modelMem[a] = hit ? faulty(d, 1'b0) : d;
            expLat      = 1;
        end else begin
            modelRdata = hit ? faulty(modelMem[a], 1'b1) : modelMem[a];
            expLat     = RD_LAT;
        end
        if (hit && modelHits < 255) modelHits++;

        bus.req   = 1'b1;
        bus.we    = isWrite;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk); #1;
        checkOutput("busyAfterCapture", 32'(bus.busy), 32'd1);
        if (earlyDrop) begin
            bus.req   = 1'b0;
            bus.we    = 1'($urandom);
            bus.addr  = ADR_SIZE'($urandom);
            bus.wdata = DATA_SIZE'($urandom);
        end
        lat = 0;
        while (!bus.ack && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput(isWrite ? "writeAckLatency" : "readAckLatency", 32'(lat), 32'(expLat));
        checkOutput("rdata", 32'(bus.rdata), 32'(modelRdata));
        checkOutput("fiHits", 32'(fi_hits), 32'(modelHits));
        lastRdata = bus.rdata;
        if (!earlyDrop) begin
            for (int i = 0; i < holdCycles; i++) begin
                @(posedge clk); #1;
                checkOutput("singleAckPulse", 32'(bus.ack), 32'd0);
                checkOutput("busyWhileReqHeld", 32'(bus.busy), 32'd1);
            end
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
        checkOutput("busyRelease", 32'(bus.busy), 32'd0);
        checkOutput("ackLowAfterRelease", 32'(bus.ack), 32'd0);
    endtask

    task automatic doReset();
        rst     = 1'b1;
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        fi_en     = 1'b0;
        fi_mode   = 2'b00;
        fi_addr   = '0;
        fi_mask   = '0;
        doReset();
        checkOutput("resetAck", 32'(bus.ack), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetRdata", 32'(bus.rdata), 32'd0);
        checkOutput("resetHits", 32'(fi_hits), 32'd0);

        $display("[TB] basic read/write");
        applyStimulus(1'b0, 4'd5, 8'h00, 0, 1'b0);
        checkOutput("readAfterReset", 32'(lastRdata), 32'h00);
        applyStimulus(1'b1, 4'd3, 8'hA5, 0, 1'b0);
        applyStimulus(1'b0, 4'd3, 8'h00, 0, 1'b0);
        checkOutput("readBackA5", 32'(lastRdata), 32'hA5);
        applyStimulus(1'b0, 4'd0, 8'h00, 0, 1'b0);
        checkOutput("untouchedAddr0", 32'(lastRdata), 32'h00);
        applyStimulus(1'b0, 4'd15, 8'h00, 0, 1'b0);
        checkOutput("untouchedAddr15", 32'(lastRdata), 32'h00);

        $display("[TB] held request");
        applyStimulus(1'b1, 4'd7, 8'h3C, 5, 1'b0);
        applyStimulus(1'b0, 4'd7, 8'h00, 2, 1'b0);
        checkOutput("readBack3C", 32'(lastRdata), 32'h3C);

        $display("[TB] stuck-at-0 fault");
        fi_en = 1'b1; fi_mode = 2'b01; fi_addr = 4'd2; fi_mask = 8'h0F;
        applyStimulus(1'b1, 4'd2, 8'hFF, 0, 1'b0);
        applyStimulus(1'b0, 4'd2, 8'h00, 0, 1'b0);
        checkOutput("stuckAt0Read", 32'(lastRdata), 32'hF0);
        checkOutput("stuckAt0Hits", 32'(fi_hits), 32'd2);
        applyStimulus(1'b1, 4'd4, 8'hFF, 0, 1'b0);
        applyStimulus(1'b0, 4'd4, 8'h00, 0, 1'b0);
        checkOutput("unfaultedNeighbour", 32'(lastRdata), 32'hFF);

        $display("[TB] invert-on-read fault");
        fi_en = 1'b0;
        applyStimulus(1'b1, 4'd9, 8'h55, 0, 1'b0);
        fi_en = 1'b1; fi_mode = 2'b11; fi_addr = 4'd9; fi_mask = 8'hFF;
        applyStimulus(1'b0, 4'd9, 8'h00, 0, 1'b0);
        checkOutput("invertRead", 32'(lastRdata), 32'hAA);
        fi_en = 1'b0;
        applyStimulus(1'b0, 4'd9, 8'h00, 0, 1'b0);
        checkOutput("invertOffRead", 32'(lastRdata), 32'h55);

        $display("[TB] early request drop");
        applyStimulus(1'b1, 4'd11, 8'h77, 0, 1'b1);
        applyStimulus(1'b0, 4'd11, 8'h00, 0, 1'b1);
        checkOutput("earlyDropRead", 32'(lastRdata), 32'h77);

        $display("[TB] randomised traffic");
        for (int n = 0; n < 300; n++) begin
            logic [ADR_SIZE-1:0] a;
            if (n % 20 == 0) begin
                fi_en   = 1'($urandom);
                fi_mode = 2'($urandom);
                fi_addr = ADR_SIZE'($urandom);
                fi_mask = DATA_SIZE'($urandom);
            end
            a = ($urandom_range(0, 3) == 0) ? fi_addr : ADR_SIZE'($urandom);
            applyStimulus(1'($urandom), a, DATA_SIZE'($urandom),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
        end

        $display("[TB] hit counter saturation");
        fi_en = 1'b1; fi_mode = 2'b10; fi_addr = 4'd6; fi_mask = 8'h81;
        for (int n = 0; n < 260; n++) begin
            applyStimulus(1'b1, 4'd6, DATA_SIZE'($urandom), 0, 1'b0);
        end
        checkOutput("hitsSaturated", 32'(fi_hits), 32'd255);
        fi_en = 1'b0;

        $display("[TB] reset during read");
        applyStimulus(1'b1, 4'd3, 8'hC3, 0, 1'b0);
        applyStimulus(1'b0, 4'd3, 8'h00, 0, 1'b0);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 4'd3;
        @(posedge clk); #1;
        rst     = 1'b1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        modelReset();
        checkOutput("midResetAck", 32'(bus.ack), 32'd0);
        checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
        checkOutput("midResetRdata", 32'(bus.rdata), 32'd0);
        checkOutput("midResetHits", 32'(fi_hits), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("noAckAfterReset", 32'(bus.ack), 32'd0);
        end
        applyStimulus(1'b0, 4'd3, 8'h00, 0, 1'b0);
        checkOutput("clearedAddr3", 32'(lastRdata), 32'h00);
        applyStimulus(1'b0, 4'd11, 8'h00, 0, 1'b0);
        checkOutput("clearedAddr11", 32'(lastRdata), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
